tlb_op_ctrl: RTL and testbench
==============================

Name: tlb_op_ctrl

Overview:
- EX-stage initiator for TLB maintenance instructions: TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB.
- Accepts one decoded TLB op at a time from the issue logic.
- Drives the enable/operand side of the ex-to-TLB interface and captures the returned search/read results.
- Produces a one-cycle CSR write-back bundle (TLBIDX/TLBEHI/TLBELO0/TLBELO1/ASID) and stalls the pipeline while busy.

Parameters:
- TLBNUM, 32, number of TLB entries; rand_index width is $clog2(TLBNUM).
- IDXW, 5, width of the index fields in TLBIDX and on the search port.

Ports:
- clk in 1: clock.
- rst_n in 1: synchronous reset, active-low.
- op_valid in 1: decoded TLB op presented.
- op_type in 3: 0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV; 5-7 are illegal.
- op_inv_op in 5: INVTLB op code.
- op_inv_asid in 10: INVTLB asid operand.
- op_inv_vpn in 19: INVTLB va[31:13] operand.
- flush in 1: pipeline flush from an older exception/ertn.
- op_ready out 1: high only in IDLE; the op is accepted when op_valid && op_ready && !flush.
- busy out 1: stall request to the front-end; high in every non-IDLE state.
- tlbsrch_en, tlbrd_en, tlbwr_en, tlbfill_en, invtlb_en out 1 each: one-cycle request pulses.
- invtlb_op out 5, invtlb_asid out 10, invtlb_vpn out 19: INVTLB operands, registered.
- rand_index out IDXW: fill index.
- tlbsrch_ret in 1, tlbrd_ret in 1: responder acknowledges, arriving one cycle after the matching enable.
- search_tlb_found in 1, search_tlb_index in IDXW: search result, valid with tlbsrch_ret.
- tlbrd_valid in 1: E bit of the entry read, valid with tlbrd_ret.
- tlbehi_out, tlbelo0_out, tlbelo1_out, tlbidx_out in 32 each: TLBRD data, valid with tlbrd_ret.
- asid_out in 10: TLBRD asid, valid with tlbrd_ret.
- wb_valid out 1: one-cycle CSR write-back strobe.
- wb_we out 5: per-CSR write enables, bit order {asid, elo1, elo0, ehi, idx}.
- wb_tlbidx, wb_tlbehi, wb_tlbelo0, wb_tlbelo1 out 32 each: CSR write data.
- wb_tlbidx_mask out 32: bitwise write mask for TLBIDX.
- wb_asid out 10: ASID write data.
- op_ine out 1: one-cycle illegal-instruction flag.

Behaviour:
- Reset (rst_n low at a clk edge):
  - State returns to IDLE.
  - All enables, wb_valid, wb_we, op_ine and busy are 0; all data outputs are 0.
  - rand_index counter is 0.
  - Reset mid-operation abandons the op; no write-back occurs.
- FSM states: IDLE, ISSUE, WAIT, WB, DRAIN.
- IDLE:
  - On accept, latch the op and go to ISSUE.
  - op_type>=5, or INV with op_inv_op>6: do not issue. Pulse op_ine for one cycle on the next cycle, stay IDLE.
- ISSUE (exactly one cycle):
  - Assert exactly one enable, selected by op_type. INV operands are driven the same cycle.
  - SRCH/RD go to WAIT.
  - WR/FILL/INV go to WB with wb_we=0: wb_valid still pulses so the pipeline retires; there is no CSR change.
- WAIT:
  - Capture on the matching *_ret, then go to WB.
  - A mismatched ret is ignored.
  - Latency from accept to wb_valid is 3 cycles for SRCH/RD and 2 cycles for WR/FILL/INV.
- SRCH result:
  - found: wb_we=idx; wb_tlbidx={NE=0, ..., index}; mask covers bit31 and bits IDXW-1:0.
  - not found: wb_tlbidx bit31=1; mask covers bit31 only; index is unchanged.
- RD result:
  - tlbrd_valid=1: wb_we=5'b11111; data comes from the *_out inputs. TLBIDX mask covers bit31 and PS[29:24]; index is never written.
  - tlbrd_valid=0: wb_we=5'b11111; EHI, ELO0, ELO1 and ASID are all written 0; TLBIDX gets NE=1 and PS=0 under the same mask.
- WB: wb_valid high for one cycle, then IDLE. op_ready returns the following cycle, so back-to-back ops are spaced at least 3/4 cycles apart.
- Flush:
  - In IDLE: blocks acceptance.
  - In ISSUE: the enable is still driven (already committed), but the op goes to DRAIN instead of WB.
  - In WAIT: go to DRAIN.
  - DRAIN: wait for the outstanding ret, or leave after 1 cycle for WR/FILL/INV, then go to IDLE with no wb_valid.
  - Flush in WB: wb_valid is suppressed.
- rand_index:
  - Free-running counter, +1 mod TLBNUM every cycle.
  - Wraps from TLBNUM-1 to 0.
  - Sampled into an output register at accept, so it is stable during the FILL ISSUE cycle.
- Enables are registered outputs; there is no combinational path from op_valid to any enable.

Test Plan:
- SRCH hit: accept at cycle 0 → tlbsrch_en=1 at cycle 1; drive tlbsrch_ret=1, found=1, index=5'd17 at cycle 2 → cycle 3: wb_valid=1, wb_we=00001, wb_tlbidx=0x00000011, mask=0x8000001F.
- SRCH miss: as above with found=0 → wb_tlbidx=0x80000000, mask=0x80000000.
- RD invalid: tlbrd_ret=1, tlbrd_valid=0, ehi_out=0xFFFFE000 → wb_we=11111, wb_tlbehi=0, wb_asid=0, wb_tlbidx=0x80000000, mask=0xBF000000.
- FILL: accept when the counter shows 30 → tlbfill_en=1 for one cycle with rand_index=30 → wb_valid at +2 with wb_we=0. The counter wraps 31→0 on the following cycles.
- INV with op_inv_op=7 → no invtlb_en; op_ine=1 for one cycle; busy never asserts. With op_inv_op=5, asid=0x3A, vpn=0x12345 → invtlb_en with those operands.
- RD with flush asserted in WAIT → tlbrd_ret consumed, no wb_valid, op_ready=1 two cycles later. Reset asserted mid-WAIT → all outputs 0 on the next edge.

Source files
------------

// File: rtl/tlb_op_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tlb_op_ctrl
// Brief   : EX-stage sequencer for TLB maintenance ops (SRCH/RD/WR/FILL/INV)
// Revision: 1.0 - initial release
// ============================================================================
module tlb_op_ctrl #(
  parameter int TLBNUM = 32,
  parameter int IDXW   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  input  logic [2:0]        op_type,
  input  logic [4:0]        op_inv_op,
  input  logic [9:0]        op_inv_asid,
  input  logic [18:0]       op_inv_vpn,
  input  logic              flush,
  output logic              op_ready,
  output logic              busy,
  output logic              tlbsrch_en,
  output logic              tlbrd_en,
  output logic              tlbwr_en,
  output logic              tlbfill_en,
  output logic              invtlb_en,
  output logic [4:0]        invtlb_op,
  output logic [9:0]        invtlb_asid,
  output logic [18:0]       invtlb_vpn,
  output logic [IDXW-1:0]   rand_index,
  input  logic              tlbsrch_ret,
  input  logic              tlbrd_ret,
  input  logic              search_tlb_found,
  input  logic [IDXW-1:0]   search_tlb_index,
  input  logic              tlbrd_valid,
  input  logic [31:0]       tlbehi_out,
  input  logic [31:0]       tlbelo0_out,
  input  logic [31:0]       tlbelo1_out,
  input  logic [31:0]       tlbidx_out,
  input  logic [9:0]        asid_out,
  output logic              wb_valid,
  output logic [4:0]        wb_we,
  output logic [31:0]       wb_tlbidx,
  output logic [31:0]       wb_tlbehi,
  output logic [31:0]       wb_tlbelo0,
  output logic [31:0]       wb_tlbelo1,
  output logic [31:0]       wb_tlbidx_mask,
  output logic [9:0]        wb_asid,
  output logic              op_ine
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_WB    = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  localparam logic [2:0]  c_op_srch = 3'd0;
  localparam logic [2:0]  c_op_rd   = 3'd1;
  localparam logic [2:0]  c_op_wr   = 3'd2;
  localparam logic [2:0]  c_op_fill = 3'd3;
  localparam logic [2:0]  c_op_inv  = 3'd4;
  localparam int          c_cntw    = (TLBNUM > 1) ? $clog2(TLBNUM) : 1;
  localparam logic [c_cntw-1:0] c_cnt_max = c_cntw'(TLBNUM - 1);
  localparam logic [31:0] c_ne_bit       = 32'h8000_0000;
  localparam logic [31:0] c_mask_found   = 32'h8000_0000 | ((32'h1 << IDXW) - 32'h1);
  localparam logic [31:0] c_mask_rd      = 32'hBF00_0000;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_op;
  logic              r_pending;
  logic [4:0]        r_we;
  logic [c_cntw-1:0] r_cnt;
  logic              w_accept;
  logic              w_illegal;
  logic              w_ret_match;
  logic              w_capture;

  assign w_accept    = op_valid && (r_state == S_IDLE) && !flush;
  assign w_illegal   = (op_type > c_op_inv) || ((op_type == c_op_inv) && (op_inv_op > 5'd6));
  assign w_ret_match = ((r_op == c_op_srch) && tlbsrch_ret) || ((r_op == c_op_rd) && tlbrd_ret);
  assign w_capture   = (r_state == S_WAIT) && !flush && w_ret_match;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    op_ready    = 1'b0;
    busy        = 1'b1;
    wb_valid    = 1'b0;
    wb_we       = 5'd0;
    case (r_state)
      S_IDLE: begin
        op_ready = 1'b1;
        busy     = 1'b0;
        if (w_accept && !w_illegal) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (flush)          w_state_nxt = S_DRAIN;
        else if (r_pending) w_state_nxt = S_WAIT;
        else                w_state_nxt = S_WB;
      end
      S_WAIT: begin
        if (flush)            w_state_nxt = S_DRAIN;
        else if (w_ret_match) w_state_nxt = S_WB;
      end
      S_WB: begin
        wb_valid    = !flush;
        wb_we       = flush ? 5'd0 : r_we;
        w_state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        // A ret seen while flushing out of WAIT already cleared r_pending.
        if (!r_pending || w_ret_match) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op           <= 3'd0;
      r_pending      <= 1'b0;
      r_we           <= 5'd0;
      r_cnt          <= '0;
      tlbsrch_en     <= 1'b0;
      tlbrd_en       <= 1'b0;
      tlbwr_en       <= 1'b0;
      tlbfill_en     <= 1'b0;
      invtlb_en      <= 1'b0;
      invtlb_op      <= 5'd0;
      invtlb_asid    <= 10'd0;
      invtlb_vpn     <= 19'd0;
      rand_index     <= '0;
      op_ine         <= 1'b0;
      wb_tlbidx      <= 32'd0;
      wb_tlbidx_mask <= 32'd0;
      wb_tlbehi      <= 32'd0;
      wb_tlbelo0     <= 32'd0;
      wb_tlbelo1     <= 32'd0;
      wb_asid        <= 10'd0;
    end else begin
      r_cnt      <= (r_cnt == c_cnt_max) ? '0 : r_cnt + 1'b1;
      tlbsrch_en <= 1'b0;
      tlbrd_en   <= 1'b0;
      tlbwr_en   <= 1'b0;
      tlbfill_en <= 1'b0;
      invtlb_en  <= 1'b0;
      op_ine     <= w_accept && w_illegal;

      if (((r_state == S_WAIT) || (r_state == S_DRAIN)) && w_ret_match) r_pending <= 1'b0;

      if (w_accept && !w_illegal) begin
        r_op           <= op_type;
        r_pending      <= (op_type == c_op_srch) || (op_type == c_op_rd);
        r_we           <= 5'd0;
        rand_index     <= IDXW'(r_cnt);
        tlbsrch_en     <= (op_type == c_op_srch);
        tlbrd_en       <= (op_type == c_op_rd);
        tlbwr_en       <= (op_type == c_op_wr);
        tlbfill_en     <= (op_type == c_op_fill);
        invtlb_en      <= (op_type == c_op_inv);
        wb_tlbidx      <= 32'd0;
        wb_tlbidx_mask <= 32'd0;
        wb_tlbehi      <= 32'd0;
        wb_tlbelo0     <= 32'd0;
        wb_tlbelo1     <= 32'd0;
        wb_asid        <= 10'd0;
        if (op_type == c_op_inv) begin
          invtlb_op   <= op_inv_op;
          invtlb_asid <= op_inv_asid;
          invtlb_vpn  <= op_inv_vpn;
        end
      end

      if (w_capture) begin
        if (r_op == c_op_srch) begin
          r_we <= 5'b00001;
          if (search_tlb_found) begin
            wb_tlbidx      <= 32'(search_tlb_index);
            wb_tlbidx_mask <= c_mask_found;
          end else begin
            wb_tlbidx      <= c_ne_bit;
            wb_tlbidx_mask <= c_ne_bit;
          end
        end else begin
          // Index field is never touched by TLBRD; only NE and PS go through the mask.
          r_we           <= 5'b11111;
          wb_tlbidx_mask <= c_mask_rd;
          if (tlbrd_valid) begin
            wb_tlbidx  <= tlbidx_out & ~c_ne_bit;
            wb_tlbehi  <= tlbehi_out;
            wb_tlbelo0 <= tlbelo0_out;
            wb_tlbelo1 <= tlbelo1_out;
            wb_asid    <= asid_out;
          end else begin
            wb_tlbidx  <= c_ne_bit;
            wb_tlbehi  <= 32'd0;
            wb_tlbelo0 <= 32'd0;
            wb_tlbelo1 <= 32'd0;
            wb_asid    <= 10'd0;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tlb_op_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_tlb_op_ctrl
// Brief   : Scoreboard bench for tlb_op_ctrl; expected write-backs are queued at stimulus time
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_tlb_op_ctrl;
  localparam int TLBNUM = 32;
  localparam int IDXW   = 5;
  localparam logic [2:0] SRCH = 3'd0, RD = 3'd1, WR = 3'd2, FILL = 3'd3, INV = 3'd4;

  typedef logic [174:0] wbv_t;
  typedef struct packed { wbv_t val; wbv_t care; } exp_t;
  localparam wbv_t CARE_WE  = {5'h1f, 170'd0};
  localparam wbv_t CARE_IDX = {5'h1f, 64'hFFFF_FFFF_FFFF_FFFF, 106'd0};
  localparam wbv_t CARE_ALL = {175{1'b1}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0, op_valid = 1'b0, flush = 1'b0;
  logic [2:0] op_type = 3'd0;
  logic [4:0] op_inv_op = 5'd0;
  logic [9:0] op_inv_asid = 10'd0;
  logic [18:0] op_inv_vpn = 19'd0;
  logic tlbsrch_ret = 1'b0, tlbrd_ret = 1'b0, search_tlb_found = 1'b0, tlbrd_valid = 1'b0;
  logic [IDXW-1:0] search_tlb_index = '0;
  logic [31:0] tlbehi_out = 32'd0, tlbelo0_out = 32'd0, tlbelo1_out = 32'd0, tlbidx_out = 32'd0;
  logic [9:0] asid_out = 10'd0;
  logic op_ready, busy, tlbsrch_en, tlbrd_en, tlbwr_en, tlbfill_en, invtlb_en;
  logic [4:0] invtlb_op;
  logic [9:0] invtlb_asid;
  logic [18:0] invtlb_vpn;
  logic [IDXW-1:0] rand_index;
  logic wb_valid, op_ine;
  logic [4:0] wb_we;
  logic [31:0] wb_tlbidx, wb_tlbehi, wb_tlbelo0, wb_tlbelo1, wb_tlbidx_mask;
  logic [9:0] wb_asid;
  logic [4:0] ens;
  assign ens = {tlbsrch_en, tlbrd_en, tlbwr_en, tlbfill_en, invtlb_en};

  tlb_op_ctrl #(.TLBNUM(TLBNUM), .IDXW(IDXW)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_type(op_type),
    .op_inv_op(op_inv_op), .op_inv_asid(op_inv_asid), .op_inv_vpn(op_inv_vpn),
    .flush(flush), .op_ready(op_ready), .busy(busy),
    .tlbsrch_en(tlbsrch_en), .tlbrd_en(tlbrd_en), .tlbwr_en(tlbwr_en),
    .tlbfill_en(tlbfill_en), .invtlb_en(invtlb_en),
    .invtlb_op(invtlb_op), .invtlb_asid(invtlb_asid), .invtlb_vpn(invtlb_vpn),
    .rand_index(rand_index), .tlbsrch_ret(tlbsrch_ret), .tlbrd_ret(tlbrd_ret),
    .search_tlb_found(search_tlb_found), .search_tlb_index(search_tlb_index),
    .tlbrd_valid(tlbrd_valid), .tlbehi_out(tlbehi_out), .tlbelo0_out(tlbelo0_out),
    .tlbelo1_out(tlbelo1_out), .tlbidx_out(tlbidx_out), .asid_out(asid_out),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_tlbidx(wb_tlbidx), .wb_tlbehi(wb_tlbehi),
    .wb_tlbelo0(wb_tlbelo0), .wb_tlbelo1(wb_tlbelo1), .wb_tlbidx_mask(wb_tlbidx_mask),
    .wb_asid(wb_asid), .op_ine(op_ine)
  );

  exp_t sb[$];
  exp_t e;
  int n_vec = 0;
  int n_miss = 0;
  int m_cnt = 0;

  // Reference free-running counter for rand_index.
  always @(posedge clk) begin
    if (!rst_n) m_cnt <= 0;
    else        m_cnt <= (m_cnt == TLBNUM - 1) ? 0 : m_cnt + 1;
  end

  function automatic wbv_t mk(input logic [4:0] we, input logic [31:0] idx, mask, ehi, elo0, elo1,
                              input logic [9:0] asid);
    return {we, idx, mask, ehi, elo0, elo1, asid};
  endfunction

  function automatic wbv_t obs();
    return {wb_we, wb_tlbidx, wb_tlbidx_mask, wb_tlbehi, wb_tlbelo0, wb_tlbelo1, wb_asid};
  endfunction

  // Called at a negedge; returns at the negedge of the ISSUE cycle.
  task automatic send_op(input logic [2:0] t, input logic [4:0] iop = 5'd0,
                         input logic [9:0] ias = 10'd0, input logic [18:0] ivpn = 19'd0);
    int k;
    k = 0;
    while (op_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k == 20) begin
      n_vec++; n_miss++;
      $display("FAIL op_ready_timeout: op_ready=%b after %0d cycles, required 1", op_ready, k);
    end
    op_valid = 1'b1; op_type = t; op_inv_op = iop; op_inv_asid = ias; op_inv_vpn = ivpn;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({ens, wb_valid, wb_we, op_ine, busy} !== 13'd0) begin
      n_miss++;
      $display("FAIL reset_ctrl: got %h, required 0", {ens, wb_valid, wb_we, op_ine, busy});
    end
    n_vec++;
    if ({invtlb_op, invtlb_asid, invtlb_vpn, rand_index, obs()} !== '0) begin
      n_miss++;
      $display("FAIL reset_data: got %h, required 0", {invtlb_op, invtlb_asid, invtlb_vpn, rand_index, obs()});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (op_ready !== 1'b1 || busy !== 1'b0) begin
      n_miss++;
      $display("FAIL reset_idle: op_ready=%b busy=%b, required 1/0", op_ready, busy);
    end
  endtask

  task automatic test_srch();
    for (int f = 1; f >= 0; f--) begin
      send_op(SRCH);
      n_vec++;
      if (ens !== 5'b10000 || busy !== 1'b1) begin
        n_miss++;
        $display("FAIL srch_issue: en=%b busy=%b, required 10000/1", ens, busy);
      end
      @(negedge clk);
      n_vec++;
      if (ens !== 5'b00000 || wb_valid !== 1'b0) begin
        n_miss++;
        $display("FAIL srch_wait: en=%b wb_valid=%b, required 00000/0", ens, wb_valid);
      end
      tlbsrch_ret = 1'b1; search_tlb_found = f[0]; search_tlb_index = 5'd17;
      if (f == 1) sb.push_back('{mk(5'b00001, 32'h0000_0011, 32'h8000_001F, 0, 0, 0, 0), CARE_IDX});
      else        sb.push_back('{mk(5'b00001, 32'h8000_0000, 32'h8000_0000, 0, 0, 0, 0), CARE_IDX});
      @(negedge clk);
      tlbsrch_ret = 1'b0; search_tlb_found = 1'b0;
      e = sb.pop_front();
      n_vec++;
      if (wb_valid !== 1'b1 || (obs() & e.care) !== (e.val & e.care)) begin
        n_miss++;
        $display("FAIL srch_wb(found=%0d): wb_valid=%b got %h, required 1 %h", f, wb_valid, obs() & e.care, e.val & e.care);
      end
      @(negedge clk);
      n_vec++;
      if (op_ready !== 1'b1 || wb_valid !== 1'b0 || busy !== 1'b0) begin
        n_miss++;
        $display("FAIL srch_done: ready=%b wb_valid=%b busy=%b, required 1/0/0", op_ready, wb_valid, busy);
      end
    end
  endtask

  task automatic test_rd();
    // Valid entry, preceded by a mismatched search ack that must be ignored.
    send_op(RD);
    n_vec++;
    if (ens !== 5'b01000) begin
      n_miss++;
      $display("FAIL rd_issue: en=%b, required 01000", ens);
    end
    @(negedge clk);
    tlbsrch_ret = 1'b1;
    @(negedge clk);
    tlbsrch_ret = 1'b0;
    n_vec++;
    if (wb_valid !== 1'b0 || busy !== 1'b1) begin
      n_miss++;
      $display("FAIL rd_mismatch_ret: wb_valid=%b busy=%b, required 0/1", wb_valid, busy);
    end
    tlbrd_ret = 1'b1; tlbrd_valid = 1'b1; tlbehi_out = 32'h1234_5000; tlbelo0_out = 32'h0ABC_DE5F;
    tlbelo1_out = 32'h0FED_C15F; tlbidx_out = 32'h0E00_0000; asid_out = 10'h155;
    sb.push_back('{mk(5'b11111, 32'h0E00_0000, 32'hBF00_0000, 32'h1234_5000, 32'h0ABC_DE5F,
                      32'h0FED_C15F, 10'h155), CARE_ALL});
    @(negedge clk);
    tlbrd_ret = 1'b0;
    e = sb.pop_front();
    n_vec++;
    if (wb_valid !== 1'b1 || (obs() & e.care) !== (e.val & e.care)) begin
      n_miss++;
      $display("FAIL rd_valid_wb: wb_valid=%b got %h, required 1 %h", wb_valid, obs(), e.val);
    end
    @(negedge clk);
    // Invalid entry: everything but TLBIDX.NE is cleared.
    send_op(RD);
    @(negedge clk);
    tlbrd_ret = 1'b1; tlbrd_valid = 1'b0; tlbehi_out = 32'hFFFF_E000; tlbelo0_out = 32'hFFFF_FFFF;
    tlbelo1_out = 32'hFFFF_FFFF; tlbidx_out = 32'h3F00_001F; asid_out = 10'h3FF;
    sb.push_back('{mk(5'b11111, 32'h8000_0000, 32'hBF00_0000, 0, 0, 0, 0), CARE_ALL});
    @(negedge clk);
    tlbrd_ret = 1'b0;
    e = sb.pop_front();
    n_vec++;
    if (wb_valid !== 1'b1 || (obs() & e.care) !== (e.val & e.care)) begin
      n_miss++;
      $display("FAIL rd_invalid_wb: wb_valid=%b got %h, required 1 %h", wb_valid, obs(), e.val);
    end
    @(negedge clk);
  endtask

  task automatic test_fill();
    logic [4:0] targets [3];
    int k;
    targets[0] = 5'd30; targets[1] = 5'd31; targets[2] = 5'd0;
    for (int i = 0; i < 3; i++) begin
      k = 0;
      while (!(m_cnt == int'(targets[i]) && op_ready === 1'b1) && k < 70) begin
        @(negedge clk);
        k++;
      end
      if (k == 70) begin
        n_vec++; n_miss++;
        $display("FAIL fill_sync_timeout: counter %0d never reached", targets[i]);
      end
      send_op(FILL);
      sb.push_back('{mk(5'b00000, 0, 0, 0, 0, 0, 0), CARE_WE});
      n_vec++;
      if (ens !== 5'b00010 || rand_index !== targets[i]) begin
        n_miss++;
        $display("FAIL fill_issue: en=%b rand_index=%0d, required 00010/%0d", ens, rand_index, targets[i]);
      end
      @(negedge clk);
      e = sb.pop_front();
      n_vec++;
      if (wb_valid !== 1'b1 || tlbfill_en !== 1'b0 || (obs() & e.care) !== (e.val & e.care)) begin
        n_miss++;
        $display("FAIL fill_wb: wb_valid=%b fill_en=%b wb_we=%b, required 1/0/00000", wb_valid, tlbfill_en, wb_we);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_inv();
    logic [2:0] ity [3];
    logic [4:0] iop [3];
    ity[0] = INV;  iop[0] = 5'd7;
    ity[1] = 3'd5; iop[1] = 5'd0;
    ity[2] = 3'd7; iop[2] = 5'd0;
    for (int i = 0; i < 3; i++) begin
      send_op(ity[i], iop[i], 10'h3A, 19'h12345);
      n_vec++;
      if (op_ine !== 1'b1 || ens !== 5'd0 || busy !== 1'b0) begin
        n_miss++;
        $display("FAIL illegal_%0d: ine=%b en=%b busy=%b, required 1/00000/0", i, op_ine, ens, busy);
      end
      @(negedge clk);
      n_vec++;
      if (op_ine !== 1'b0 || busy !== 1'b0 || op_ready !== 1'b1) begin
        n_miss++;
        $display("FAIL illegal_after_%0d: ine=%b busy=%b ready=%b, required 0/0/1", i, op_ine, busy, op_ready);
      end
    end
    send_op(INV, 5'd5, 10'h3A, 19'h12345);
    sb.push_back('{mk(5'b00000, 0, 0, 0, 0, 0, 0), CARE_WE});
    n_vec++;
    if (ens !== 5'b00001 || invtlb_op !== 5'd5 || invtlb_asid !== 10'h3A || invtlb_vpn !== 19'h12345 || op_ine !== 1'b0) begin
      n_miss++;
      $display("FAIL inv_issue: en=%b op=%0d asid=%h vpn=%h ine=%b, required 00001/5/03a/12345/0",
               ens, invtlb_op, invtlb_asid, invtlb_vpn, op_ine);
    end
    @(negedge clk);
    e = sb.pop_front();
    n_vec++;
    if (wb_valid !== 1'b1 || (obs() & e.care) !== (e.val & e.care)) begin
      n_miss++;
      $display("FAIL inv_wb: wb_valid=%b wb_we=%b, required 1/00000", wb_valid, wb_we);
    end
    @(negedge clk);
  endtask

  task automatic test_flush();
    // Flush in IDLE blocks acceptance.
    op_valid = 1'b1; op_type = WR; flush = 1'b1;
    @(negedge clk);
    op_valid = 1'b0; flush = 1'b0;
    n_vec++;
    if (ens !== 5'd0 || busy !== 1'b0) begin
      n_miss++;
      $display("FAIL flush_idle: en=%b busy=%b, required 00000/0", ens, busy);
    end
    // Flush in ISSUE: enable still fires, drain on the ack.
    send_op(SRCH);
    flush = 1'b1;
    n_vec++;
    if (tlbsrch_en !== 1'b1) begin
      n_miss++;
      $display("FAIL flush_issue_en: srch_en=%b, required 1", tlbsrch_en);
    end
    @(negedge clk);
    flush = 1'b0; tlbsrch_ret = 1'b1; search_tlb_found = 1'b1;
    n_vec++;
    if (wb_valid !== 1'b0 || busy !== 1'b1) begin
      n_miss++;
      $display("FAIL flush_issue_drain: wb_valid=%b busy=%b, required 0/1", wb_valid, busy);
    end
    @(negedge clk);
    tlbsrch_ret = 1'b0; search_tlb_found = 1'b0;
    n_vec++;
    if (wb_valid !== 1'b0 || op_ready !== 1'b1) begin
      n_miss++;
      $display("FAIL flush_issue_done: wb_valid=%b ready=%b, required 0/1", wb_valid, op_ready);
    end
    // Flush in WAIT together with the ack.
    send_op(RD);
    @(negedge clk);
    flush = 1'b1; tlbrd_ret = 1'b1; tlbrd_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0; tlbrd_ret = 1'b0;
    n_vec++;
    if (wb_valid !== 1'b0 || op_ready !== 1'b0 || busy !== 1'b1) begin
      n_miss++;
      $display("FAIL flush_wait_drain: wb_valid=%b ready=%b busy=%b, required 0/0/1", wb_valid, op_ready, busy);
    end
    @(negedge clk);
    n_vec++;
    if (wb_valid !== 1'b0 || op_ready !== 1'b1) begin
      n_miss++;
      $display("FAIL flush_wait_done: wb_valid=%b ready=%b, required 0/1", wb_valid, op_ready);
    end
    // Flush in WB suppresses the strobe.
    send_op(WR);
    @(negedge clk);
    flush = 1'b1;
    #1;
    n_vec++;
    if (wb_valid !== 1'b0) begin
      n_miss++;
      $display("FAIL flush_wb: wb_valid=%b, required 0", wb_valid);
    end
    @(negedge clk);
    flush = 1'b0;
    n_vec++;
    if (op_ready !== 1'b1 || wb_valid !== 1'b0) begin
      n_miss++;
      $display("FAIL flush_wb_done: ready=%b wb_valid=%b, required 1/0", op_ready, wb_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] en_exp, wb_exp;
    en_exp = 6'b001001;
    wb_exp = 6'b010010;
    sb.push_back('{mk(5'b00000, 0, 0, 0, 0, 0, 0), CARE_WE});
    sb.push_back('{mk(5'b00000, 0, 0, 0, 0, 0, 0), CARE_WE});
    op_valid = 1'b1; op_type = WR;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      n_vec++;
      if (tlbwr_en !== en_exp[i-1] || wb_valid !== wb_exp[i-1]) begin
        n_miss++;
        $display("FAIL b2b_cycle%0d: wr_en=%b wb_valid=%b, required %b/%b", i, tlbwr_en, wb_valid, en_exp[i-1], wb_exp[i-1]);
      end
      if (wb_valid === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        if ((obs() & e.care) !== (e.val & e.care)) begin
          n_miss++;
          $display("FAIL b2b_wb%0d: wb_we=%b, required 00000", i, wb_we);
        end
      end
      if (i == 4) op_valid = 1'b0;
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL b2b_pending: %0d write-backs missing, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset_mid();
    send_op(RD, 5'd0, 10'h0, 19'h0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({ens, wb_valid, wb_we, op_ine, busy, invtlb_op, invtlb_asid, invtlb_vpn, rand_index, obs()} !== '0) begin
      n_miss++;
      $display("FAIL reset_mid: got %h, required 0",
               {ens, wb_valid, wb_we, op_ine, busy, invtlb_op, invtlb_asid, invtlb_vpn, rand_index, obs()});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (op_ready !== 1'b1 || wb_valid !== 1'b0) begin
      n_miss++;
      $display("FAIL reset_mid_idle: ready=%b wb_valid=%b, required 1/0", op_ready, wb_valid);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_srch();
    test_rd();
    test_fill();
    test_inv();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
